// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GUARD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011
    };

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Shared BCD to 7-segment decoder; nibbles above 9 decode to blank.
// Ports: bcd (4-bit digit in), seg (segments {a..g} out, active-high).
module bcd_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_CODE[0];
            4'd1:    seg = SEG_CODE[1];
            4'd2:    seg = SEG_CODE[2];
            4'd3:    seg = SEG_CODE[3];
            4'd4:    seg = SEG_CODE[4];
            4'd5:    seg = SEG_CODE[5];
            4'd6:    seg = SEG_CODE[6];
            4'd7:    seg = SEG_CODE[7];
            4'd8:    seg = SEG_CODE[8];
            4'd9:    seg = SEG_CODE[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with staged,
// frame-boundary commits. Ports: clk, rst_n, en, load_valid/ready/data,
// blank_lz, dp_mask in; seg_out, dp_out, an_n, frame_done, err_bcd out.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    err_bcd
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_WIDTH-1:0] DWELL_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] GUARD_LAST = DIV_WIDTH'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t                  state, nxt_state;
    logic [IDX_W-1:0]        idx, nxt_idx;
    logic [DIV_WIDTH-1:0]    cnt, nxt_cnt;
    logic [4*NUM_DIGITS-1:0] display, staging, nxt_disp;
    logic                    pending;
    logic                    commit, wrap, accept;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    run, blank, stage_bad;

    assign load_ready = ~pending;
    assign accept     = load_valid & ~pending;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        commit    = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                commit = pending;
                if (en) begin
                    nxt_state = DRIVE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            end
            DRIVE: begin
                if (!en) begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end else if (cnt == DWELL_LAST) begin
                    nxt_state = GUARD;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            GUARD: begin
                if (!en) begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end else if (cnt == GUARD_LAST) begin
                    nxt_state = DRIVE;
                    nxt_cnt   = '0;
                    if (idx == IDX_LAST) begin
                        nxt_idx = '0;
                        wrap    = 1'b1;
                        commit  = pending;
                    end else begin
                        nxt_idx = idx + 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_idx   = '0;
                nxt_cnt   = '0;
            end
        endcase
        nxt_disp = commit ? staging : display;
    end

    // lz[i]: digit i and every digit above it are zero (digit 0 excluded)
    always_comb begin
        lz  = '0;
        run = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run   = run && (nxt_disp[4*i +: 4] == 4'd0);
            lz[i] = run;
        end
    end

    always_comb begin
        stage_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            stage_bad = stage_bad | (staging[4*i +: 4] > 4'd9);
        end
    end

    assign nib   = nxt_disp[4*nxt_idx +: 4];
    assign blank = lz[nxt_idx] | (nib > 4'd9);

    bcd_seg_decode u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            display    <= '0;
            staging    <= '0;
            pending    <= 1'b0;
            an_n       <= '1;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
            err_bcd    <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            display    <= nxt_disp;
            frame_done <= wrap;
            pending    <= (pending & ~commit) | accept;
            if (accept) begin
                staging <= load_data;
            end
            if (commit) begin
                err_bcd <= stage_bad;
            end
            if (nxt_state == DRIVE && !blank) begin
                an_n    <= ~(NUM_DIGITS'(1) << nxt_idx);
                seg_out <= dec_seg;
                dp_out  <= dp_mask[nxt_idx];
            end else begin
                an_n    <= '1;
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, dwell 4, guard 1).
// Expected scan outputs are queued per cycle and popped on falling edges.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        err_bcd;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .DIV_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_n       (an_n),
        .frame_done (frame_done),
        .err_bcd    (err_bcd)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic        blz;
        logic [3:0]  dpm;
        logic [27:0] segs;
        logic [3:0]  lit;
        logic        err;
    } vec_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if ({an_n, seg_out, dp_out, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                n_fail++;
                $display("FAIL scan t=%0t: an_n=%b seg=%b dp=%b fd=%b, expected an_n=%b seg=%b dp=%b fd=%b",
                         $time, an_n, seg_out, dp_out, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push_ent(input logic [3:0] an, input logic [6:0] seg,
                            input logic dp, input logic fd);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.dp  = dp;
        e.fd  = fd;
        q.push_back(e);
    endtask

    task automatic push_idle();
        push_ent(4'hf, 7'h00, 1'b0, 1'b0);
    endtask

    // Digit slots 0..ndig-1: four drive cycles then one guard cycle each
    task automatic push_digits(input logic [27:0] segs, input logic [3:0] lit,
                               input logic [3:0] dpm, input int ndig,
                               input logic fd_first);
        for (int d = 0; d < ndig; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] an;
                an = lit[d] ? ~(4'b0001 << d) : 4'hf;
                push_ent(an, lit[d] ? segs[7*d +: 7] : 7'h00,
                         lit[d] & dpm[d], (d == 0 && c == 0) ? fd_first : 1'b0);
            end
            push_ent(4'hf, 7'h00, 1'b0, 1'b0);
        end
    endtask

    // From IDLE with en=0: accept a load, commit it in IDLE
    task automatic load_commit(input logic [15:0] data, input logic blz,
                               input logic [3:0] dpm, input logic exp_err);
        blank_lz   = blz;
        dp_mask    = dpm;
        load_data  = data;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("ready_pending", load_ready, 0);
        step();
        chk("ready_commit", load_ready, 1);
        chk("err_bcd", err_bcd, exp_err);
    endtask

    task automatic scan(input logic [27:0] segs, input logic [3:0] lit,
                        input logic [3:0] dpm, input int nfr);
        push_idle();
        for (int k = 0; k < nfr; k++) begin
            push_digits(segs, lit, dpm, 4, k > 0);
        end
        en = 1'b1;
        repeat (20 * nfr) step();
        en = 1'b0;
        step();
        chk("idle_an", an_n, 4'hf);
    endtask

    localparam logic [27:0] S1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
    localparam logic [27:0] S0056 = {7'h00, 7'h00, 7'h5B, 7'h5F};
    localparam logic [27:0] S0000 = {7'h00, 7'h00, 7'h00, 7'h7E};

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 4'b0000, S1234, 4'b1111, 1'b0};
        vecs[1] = '{16'h00A9, 1'b0, 4'b0000, {7'h7E, 7'h7E, 7'h00, 7'h7B}, 4'b1101, 1'b1};
        vecs[2] = '{16'h0056, 1'b1, 4'b0000, S0056, 4'b0011, 1'b0};
        vecs[3] = '{16'h0000, 1'b1, 4'b0000, S0000, 4'b0001, 1'b0};
        vecs[4] = '{16'h0100, 1'b1, 4'b0000, {7'h00, 7'h30, 7'h7E, 7'h7E}, 4'b0111, 1'b0};
        vecs[5] = '{16'h9807, 1'b1, 4'b1010, {7'h7B, 7'h7F, 7'h7E, 7'h70}, 4'b1111, 1'b0};
        vecs[6] = '{16'h0F00, 1'b0, 4'b0000, {7'h7E, 7'h00, 7'h7E, 7'h7E}, 4'b1011, 1'b1};
        vecs[7] = '{16'h00B0, 1'b1, 4'b0000, S0000, 4'b0001, 1'b1};

        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        blank_lz   = 1'b0;
        dp_mask    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an_n", an_n, 4'hf);
        chk("rst_seg", seg_out, 0);
        chk("rst_dp", dp_out, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_err", err_bcd, 0);
        chk("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        step();
        chk("idle_an_en0", an_n, 4'hf);

        for (int v = 0; v < 8; v++) begin
            load_commit(vecs[v].data, vecs[v].blz, vecs[v].dpm, vecs[v].err);
            scan(vecs[v].segs, vecs[v].lit, vecs[v].dpm, 1);
        end

        // Mid-frame load: 1234 holds until the wrap, then 0056 appears
        load_commit(16'h1234, 1'b1, 4'b0000, 1'b0);
        push_idle();
        push_digits(S1234, 4'b1111, 4'b0000, 4, 1'b0);
        push_digits(S0056, 4'b0011, 4'b0000, 4, 1'b1);
        en = 1'b1;
        repeat (5) step();
        load_data  = 16'h0056;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("mid_ready_drop", load_ready, 0);
        repeat (14) step();
        chk("ready_before_wrap", load_ready, 0);
        step();
        chk("ready_after_wrap", load_ready, 1);
        repeat (19) step();
        en = 1'b0;
        step();
        chk("mid_idle_an", an_n, 4'hf);
        chk("mid_err", err_bcd, 0);

        // Drop en while digit 2 is driven, then restart at digit 0
        load_commit(16'h1234, 1'b0, 4'b0001, 1'b0);
        push_idle();
        push_digits(S1234, 4'b1111, 4'b0001, 2, 1'b0);
        push_ent(4'b1011, 7'h6D, 1'b0, 1'b0);
        push_ent(4'b1011, 7'h6D, 1'b0, 1'b0);
        en = 1'b1;
        repeat (12) step();
        en = 1'b0;
        push_idle();
        step();
        chk("drop_an", an_n, 4'hf);
        chk("drop_seg", seg_out, 0);
        en = 1'b1;
        push_digits(S1234, 4'b1111, 4'b0001, 4, 1'b0);
        repeat (20) step();
        en = 1'b0;
        step();
        chk("drop_idle_an", an_n, 4'hf);

        // Async reset mid-DRIVE with a load pending
        load_commit(16'h1234, 1'b0, 4'b0000, 1'b0);
        en = 1'b1;
        repeat (2) step();
        load_data  = 16'h9876;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("rst6_pending", load_ready, 0);
        chk("rst6_lit", an_n, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst6_an", an_n, 4'hf);
        chk("rst6_seg", seg_out, 0);
        chk("rst6_dp", dp_out, 0);
        chk("rst6_ready", load_ready, 1);
        chk("rst6_fd", frame_done, 0);
        en       = 1'b0;
        blank_lz = 1'b1;
        dp_mask  = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        scan(S0000, 4'b0001, 4'b0000, 2);
        chk("rst6_ready_end", load_ready, 1);
        chk("rst6_err_end", err_bcd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment display.
- Holds a committed BCD frame and steps through the digits. For each digit it routes the nibble through one shared BCD-to-7-segment decoder and drives that digit's anode. A guard interval with all anodes off sits between digits to stop ghosting.
- New values come in over a valid/ready port, are staged, and are committed only at a frame boundary, so the display never shows a half-updated number.
- Sits between the counter/ALU datapaths and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; digit 0 is least significant.
- REFRESH_DIV, 50000, clk cycles each digit is driven (at least 1).
- GUARD_CYCLES, 2, clk cycles with all anodes off between digits (at least 1).
- DIV_WIDTH, 16, width of the dwell/guard counter; must hold max(REFRESH_DIV, GUARD_CYCLES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  staging register empty; a load is accepted when load_valid && load_ready.
- load_data  in  4*NUM_DIGITS  BCD digits; nibble i (load_data[4i+3:4i]) is digit i.
- blank_lz  in  1  leading-zero blanking enable; sampled every cycle.
- dp_mask  in  NUM_DIGITS  decimal-point enable per digit; sampled every cycle.
- seg_out  out  7  segments {a,b,c,d,e,f,g}, active-high.
- dp_out  out  1  decimal point, active-high.
- an_n  out  NUM_DIGITS  digit anodes, active-low, one-hot-low or all ones.
- frame_done  out  1  one-cycle pulse at each frame wrap.
- err_bcd  out  1  committed frame contains a nibble greater than 9.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, digit index 0, counter 0, display and staging registers 0, pending flag 0.
  - an_n all 1, seg_out 0, dp_out 0, load_ready 1, frame_done 0, err_bcd 0.
- Outputs are registered and computed from next-state values, so an_n and seg_out change on the same edge as the state.
- Segment codes, digits 0-9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011. Nibbles 10-15 decode to 0000000.
- States:
  - IDLE: en=0. an_n all 1, seg_out 0, dp_out 0. If pending, commit the staging register to the display register immediately. When en=1, go to DRIVE with index 0 and counter 0.
  - DRIVE: an_n[idx]=0 and seg_out=decode(display[idx]). dp_out=dp_mask[idx]. The counter runs 0..REFRESH_DIV-1, then the state goes to GUARD with counter reset.
  - GUARD: an_n all 1, seg_out 0, dp_out 0, for GUARD_CYCLES cycles. Then the index advances.
    - If the index was NUM_DIGITS-1: it wraps to 0, frame_done pulses on that edge, and any pending data commits on that same edge.
    - The state then returns to DRIVE.
- Frame period = NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
- en=0 in DRIVE or GUARD: IDLE on the next edge, index and counter reset to 0. Re-enabling always restarts at digit 0, counter 0.
- Handshake:
  - An accepted load writes the staging register and sets pending; load_ready=!pending.
  - A commit clears pending, and load_ready returns high on the following cycle.
  - A load accepted on the commit edge itself (pending was 0) stays staged until the next frame boundary.
- Leading-zero blanking: when blank_lz=1, contiguous zero digits from NUM_DIGITS-1 downward are blanked (anode held off, seg_out 0, dp_out 0). Digit 0 is never blanked.
- Invalid nibble: that digit is blanked the same way. err_bcd is updated at every commit: 1 if any committed nibble is greater than 9.
- Reset asserted mid-frame forces all reset values immediately, including discarding pending data.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_CODE[0:9] table and SEG_BLANK=7'b0000000.
  - State enum {IDLE, DRIVE, GUARD}.
- One sub-module, bcd_seg_decode: combinational 4-bit to 7-bit decoder with a default-blank branch, instantiated once and shared across all digits.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, frame period 20 cycles):
1. Reset, en=0 -> an_n=1111, seg_out=0000000, load_ready=1, err_bcd=0, frame_done=0.
2. Load 16'h1234 in IDLE, then en=1:
   - an_n=1110 with seg_out=0110011 (digit "4") for 4 cycles, then 1111 for 1 cycle.
   - Then an_n=1101 with seg_out=1111001 (digit "3").
   - frame_done pulses every 20 cycles.
3. Mid-frame load of 16'h0056 with blank_lz=1:
   - load_ready drops, and 1234 keeps displaying until the wrap.
   - Next frame: digits 3 and 2 show an_n=1111, digit 1 shows 1011011, digit 0 shows 1011111.
   - load_ready returns to 1 one cycle after the wrap.
4. Load 16'h00A9, blank_lz=0 -> after commit err_bcd=1, digit 1 is blanked, digit 0 shows 1111011, digits 3 and 2 show 1111110.
5. en dropped while digit 2 is driven -> next edge an_n=1111, seg_out=0. With dp_mask=0001, re-enable gives digit 0 first with counter 0 and dp_out=1.
6. rst_n pulsed low mid-DRIVE with a load pending -> outputs take reset values asynchronously and the pending data is discarded. With blank_lz=1 after restart, only digit 0 is lit, with seg_out=1111110.
